led_duty_sequencer: RTL and testbench

Controller that sequences the duty-cycle setpoint for the LED PWM stage. Two raw push-keys are synchronised, debounced and sampled on a slow step tick. In MANUAL mode the keys raise or lower brightness. Pressing both keys toggles AUTO "breathing" mode, which ramps duty up and down continuously. Output duty feeds the PWM comparator; duty_upd tells downstream logic that a new value is present.

---
 rtl/led_pkg.sv | 19 +
 rtl/key_debounce.sv | 42 ++++
 rtl/led_duty_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_duty_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED duty-cycle sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      MANUAL,
      AUTO_UP,
      AUTO_DOWN,
      TOGGLE_WAIT
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   localparam logic [1:0] KEY_NONE = 2'b00;
   localparam logic [1:0] KEY_UP   = 2'b01;
   localparam logic [1:0] KEY_DN   = 2'b10;
   localparam logic [1:0] KEY_BOTH = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// Single-bit key conditioner: 2-flop synchroniser followed by a stability counter.
module key_debounce #(
   parameter int unsigned DEB_CYC = 65536
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean
);

   localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          clean_q;
   logic [CW-1:0] cnt_q;

   // Counter tracks consecutive clocks of disagreement; any agreement restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         if (sync2_q == clean_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            clean_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign clean = clean_q;

endmodule

// File: rtl/led_duty_sequencer.sv
// Duty setpoint sequencer: debounced keys, slow step tick, manual/auto breathing FSM.
module led_duty_sequencer
   import led_pkg::*;
#(
   parameter int unsigned DUTY_W     = 10,
   parameter int unsigned STEP       = 1,
   parameter int unsigned TICK_DIV   = 32768,
   parameter int unsigned DEB_CYC    = 65536,
   parameter int unsigned RESET_DUTY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        key,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd,
   output logic              mode,
   output logic              at_limit
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX   = {DUTY_W{1'b1}};
   localparam logic [DUTY_W:0]   MAX_X      = {1'b0, DUTY_MAX};
   localparam logic [DUTY_W:0]   STEP_X     = (DUTY_W + 1)'(STEP);

   logic [1:0]        kd;
   logic [PW-1:0]     presc_q;
   logic              tick;
   logic [DUTY_W:0]   sum_x;
   logic [DUTY_W-1:0] duty_up;
   logic [DUTY_W-1:0] duty_dn;

   state_e            state_q;
   logic [DUTY_W-1:0] duty_q;
   logic              mode_q;
   logic              upd_q;
   logic              tgt_auto_q;

   key_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_deb_up (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (key[0]),
      .clean (kd[0])
   );

   key_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_deb_dn (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (key[1]),
      .clean (kd[1])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign tick = (presc_q == PRESC_LAST);

   // One extra bit keeps the saturation compare free of wrap-around.
   always_comb begin
      sum_x   = {1'b0, duty_q} + STEP_X;
      duty_up = (sum_x > MAX_X) ? DUTY_MAX : sum_x[DUTY_W-1:0];
      duty_dn = ({1'b0, duty_q} >= STEP_X) ? (duty_q - STEP_X[DUTY_W-1:0]) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MANUAL;
         duty_q     <= DUTY_W'(RESET_DUTY);
         mode_q     <= MODE_MANUAL;
         upd_q      <= 1'b0;
         tgt_auto_q <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         if (tick) begin
            unique case (state_q)
               MANUAL: begin
                  case (kd)
                     KEY_UP: begin
                        duty_q <= duty_up;
                        upd_q  <= (duty_up != duty_q);
                     end
                     KEY_DN: begin
                        duty_q <= duty_dn;
                        upd_q  <= (duty_dn != duty_q);
                     end
                     KEY_BOTH: begin
                        state_q    <= TOGGLE_WAIT;
                        tgt_auto_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               AUTO_UP: begin
                  if (kd == KEY_BOTH) begin
                     state_q    <= TOGGLE_WAIT;
                     tgt_auto_q <= 1'b0;
                  end else begin
                     duty_q <= duty_up;
                     upd_q  <= (duty_up != duty_q);
                     if (duty_up == DUTY_MAX) begin
                        state_q <= AUTO_DOWN;
                     end
                  end
               end
               AUTO_DOWN: begin
                  if (kd == KEY_BOTH) begin
                     state_q    <= TOGGLE_WAIT;
                     tgt_auto_q <= 1'b0;
                  end else begin
                     duty_q <= duty_dn;
                     upd_q  <= (duty_dn != duty_q);
                     if (duty_dn == '0) begin
                        state_q <= AUTO_UP;
                     end
                  end
               end
               TOGGLE_WAIT: begin
                  // Only a full release commits the toggle, so a held pair never re-fires.
                  if (kd == KEY_NONE) begin
                     if (tgt_auto_q) begin
                        state_q <= AUTO_UP;
                        mode_q  <= MODE_AUTO;
                     end else begin
                        state_q <= MANUAL;
                        mode_q  <= MODE_MANUAL;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign duty     = duty_q;
   assign duty_upd = upd_q;
   assign mode     = mode_q;
   assign at_limit = (duty_q == '0) || (duty_q == DUTY_MAX);

endmodule

// File: tb/tb_led_duty_sequencer.sv
// Randomised self-checking bench for led_duty_sequencer against a behavioural model.
module tb_led_duty_sequencer;

   localparam int unsigned DUTY_W     = 4;
   localparam int unsigned STEP       = 1;
   localparam int unsigned TICK_DIV   = 4;
   localparam int unsigned DEB_CYC    = 3;
   localparam int unsigned RESET_DUTY = 0;
   localparam int          DMAX       = (1 << DUTY_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        key = 2'b00;
   logic [DUTY_W-1:0] duty;
   logic              duty_upd;
   logic              mode;
   logic              at_limit;

   int n_chk = 0;
   int n_err = 0;
   int upd_seen = 0;

   led_duty_sequencer #(
      .DUTY_W     (DUTY_W),
      .STEP       (STEP),
      .TICK_DIV   (TICK_DIV),
      .DEB_CYC    (DEB_CYC),
      .RESET_DUTY (RESET_DUTY)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key      (key),
      .duty     (duty),
      .duty_upd (duty_upd),
      .mode     (mode),
      .at_limit (at_limit)
   );

   always #5 clk = ~clk;

   // Behavioural model: key history, run lengths, and a mode/direction/pending-toggle view.
   int m_s1, m_s2, m_kd, m_presc;
   int m_run [2];
   int m_duty, m_mode, m_dir, m_upd, m_pending, m_target;

   function automatic int clampd(int v);
      if (v > DMAX) return DMAX;
      if (v < 0) return 0;
      return v;
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_kd = 0; m_presc = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_duty = RESET_DUTY; m_mode = 0; m_dir = 1; m_upd = 0;
      m_pending = 0; m_target = 0;
   endtask

   task automatic model_step();
      int nd;
      nd = m_duty;
      if (m_presc == TICK_DIV - 1) begin
         if (m_pending != 0) begin
            if (m_kd == 0) begin
               m_pending = 0;
               m_mode = m_target;
               m_dir = 1;
            end
         end else if (m_kd == 3) begin
            m_pending = 1;
            m_target = 1 - m_mode;
         end else if (m_mode == 0) begin
            if (m_kd == 1) nd = clampd(m_duty + STEP);
            if (m_kd == 2) nd = clampd(m_duty - STEP);
         end else begin
            nd = clampd(m_duty + m_dir * STEP);
            if (m_dir > 0 && nd == DMAX) m_dir = -1;
            else if (m_dir < 0 && nd == 0) m_dir = 1;
         end
      end
      m_upd = (nd != m_duty) ? 1 : 0;
      m_duty = nd;
      for (int b = 0; b < 2; b++) begin
         if (((m_s2 >> b) & 1) != ((m_kd >> b) & 1)) begin
            m_run[b]++;
            if (m_run[b] == DEB_CYC) begin
               m_kd = (m_kd & ~(1 << b)) | (m_s2 & (1 << b));
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = int'(key);
      m_presc = (m_presc + 1) % TICK_DIV;
   endtask

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("duty", int'(duty), m_duty);
         chk("duty_upd", int'(duty_upd), m_upd);
         chk("mode", int'(mode), m_mode);
         chk("at_limit", int'(at_limit), (m_duty == 0 || m_duty == DMAX) ? 1 : 0);
         if (duty_upd) upd_seen++;
      end
   end

   task automatic hold(logic [1:0] k, int n);
      key = k;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      base = upd_seen;
      hold(2'b00, 40);
      chk("idle_duty", int'(duty), 0);
      chk("idle_mode", int'(mode), 0);
      chk("idle_limit", int'(at_limit), 1);
      chk("idle_upd_count", upd_seen - base, 0);

      base = upd_seen;
      hold(2'b01, 80);
      hold(2'b00, 10);
      chk("up_duty", int'(duty), 15);
      chk("up_limit", int'(at_limit), 1);
      chk("up_upd_count", upd_seen - base, 15);

      hold(2'b10, 80);
      hold(2'b00, 10);
      chk("down_duty", int'(duty), 0);

      hold(2'b01, 2);
      hold(2'b00, 20);
      chk("glitch_duty", int'(duty), 0);

      hold(2'b11, 20);
      chk("toggle_held_mode", int'(mode), 0);
      chk("toggle_held_duty", int'(duty), 0);
      hold(2'b00, 12);
      chk("auto_mode", int'(mode), 1);
      hold(2'b01, 40);
      chk("auto_key_mode", int'(mode), 1);
      hold(2'b11, 20);
      hold(2'b00, 12);
      chk("manual_mode", int'(mode), 0);

      hold(2'b11, 12);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_duty", int'(duty), RESET_DUTY);
      chk("rst_upd", int'(duty_upd), 0);
      chk("rst_mode", int'(mode), 0);
      key = 2'b00;
      @(negedge clk);
      #3 rst_n = 1'b1;
      hold(2'b00, 40);
      chk("post_rst_mode", int'(mode), 0);

      for (int i = 0; i < 400; i++) begin
         hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 14)));
         if ($urandom_range(0, 60) == 0) begin
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #3 rst_n = 1'b1;
         end
      end
      hold(2'b00, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
